// File: rtl/transmitter_fetch.sv
// Fetch-stage source: owns the PC, splits instruction words into fields and
// assembles two-word immediates. Optional counter enabled by FETCH_PERF_CNT_EN.
module transmitter_fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_r,
    input  logic              reset_n_r,
    output logic [ADDR_W-1:0] imem_addr_f_t,
    input  logic [31:0]       imem_data_f_t,
    input  logic              stall_f_t,
    input  logic              branch_taken_f_t,
    input  logic [ADDR_W-1:0] branch_target_f_t,
    output logic [4:0]        opcode_out_f_t,
    output logic [3:0]        s1_out_f_t,
    output logic [3:0]        s2_out_f_t,
    output logic [3:0]        dest_out_f_t,
    output logic [31:0]       ime_data_out_f_t,
    output logic              valid_out_f_t,
    output logic [31:0]       instr_count_f_t
);
    localparam logic [4:0] HALT_OP = 5'b01111;

    typedef enum logic [1:0] {FETCH, FETCH_IMM, HALTED} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [4:0]        pend_opcode;
    logic [3:0]        pend_dest;
    logic [3:0]        pend_s1;
    logic [3:0]        pend_s2;

    logic [4:0] word_opcode;
    logic [3:0] word_dest;
    logic [3:0] word_s1;
    logic [3:0] word_s2;
    logic       word_is_imm;
    logic       word_is_halt;

    assign word_opcode   = imem_data_f_t[31:27];
    assign word_dest     = imem_data_f_t[26:23];
    assign word_s1       = imem_data_f_t[22:19];
    assign word_s2       = imem_data_f_t[18:15];
    assign word_is_imm   = (word_opcode[4:3] == 2'b11);
    assign word_is_halt  = (word_opcode == HALT_OP);
    assign imem_addr_f_t = pc;

    // Branch beats stall beats normal fetch; a stall holds every register so
    // the receiver re-samples the same instruction.
    always_ff @(posedge clk_r or negedge reset_n_r) begin
        if (!reset_n_r) begin
            state            <= FETCH;
            pc               <= RESET_PC;
            pend_opcode      <= '0;
            pend_dest        <= '0;
            pend_s1          <= '0;
            pend_s2          <= '0;
            opcode_out_f_t   <= '0;
            dest_out_f_t     <= '0;
            s1_out_f_t       <= '0;
            s2_out_f_t       <= '0;
            ime_data_out_f_t <= '0;
            valid_out_f_t    <= 1'b0;
        end else if (branch_taken_f_t) begin
            state            <= FETCH;
            pc               <= branch_target_f_t;
            pend_opcode      <= '0;
            pend_dest        <= '0;
            pend_s1          <= '0;
            pend_s2          <= '0;
            opcode_out_f_t   <= '0;
            dest_out_f_t     <= '0;
            s1_out_f_t       <= '0;
            s2_out_f_t       <= '0;
            ime_data_out_f_t <= '0;
            valid_out_f_t    <= 1'b0;
        end else if (!stall_f_t) begin
            case (state)
                FETCH: begin
                    ime_data_out_f_t <= '0;
                    if (word_is_imm) begin
                        pend_opcode    <= word_opcode;
                        pend_dest      <= word_dest;
                        pend_s1        <= word_s1;
                        pend_s2        <= word_s2;
                        opcode_out_f_t <= '0;
                        dest_out_f_t   <= '0;
                        s1_out_f_t     <= '0;
                        s2_out_f_t     <= '0;
                        valid_out_f_t  <= 1'b0;
                        pc             <= pc + 1'b1;
                        state          <= FETCH_IMM;
                    end else begin
                        opcode_out_f_t <= word_opcode;
                        dest_out_f_t   <= word_dest;
                        s1_out_f_t     <= word_s1;
                        s2_out_f_t     <= word_s2;
                        valid_out_f_t  <= 1'b1;
                        if (word_is_halt) begin
                            state <= HALTED;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                FETCH_IMM: begin
                    opcode_out_f_t   <= pend_opcode;
                    dest_out_f_t     <= pend_dest;
                    s1_out_f_t       <= pend_s1;
                    s2_out_f_t       <= pend_s2;
                    ime_data_out_f_t <= imem_data_f_t;
                    valid_out_f_t    <= 1'b1;
                    pc               <= pc + 1'b1;
                    state            <= FETCH;
                end
                default: begin
                    opcode_out_f_t   <= '0;
                    dest_out_f_t     <= '0;
                    s1_out_f_t       <= '0;
                    s2_out_f_t       <= '0;
                    ime_data_out_f_t <= '0;
                    valid_out_f_t    <= 1'b0;
                    state            <= HALTED;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        issue;
    logic [31:0] count;

    // An issue is any non-stalled, non-branch edge that raises valid.
    assign issue = !branch_taken_f_t && !stall_f_t &&
                   (((state == FETCH) && !word_is_imm) || (state == FETCH_IMM));

    always_ff @(posedge clk_r or negedge reset_n_r) begin
        if (!reset_n_r) begin
            count <= '0;
        end else if (issue && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

    assign instr_count_f_t = count;
`else
    assign instr_count_f_t = '0;
`endif

endmodule
